// File: rtl/sobol_seq_gen.sv
// 1-D Sobol sequence generator using the Gray-code (Antonov-Saleev) recurrence.
// Emits one Q16.16 sample per enabled cycle from a run-time loadable direction table.
module sobol_seq_gen #(
  parameter int WIDTH      = 32,
  parameter int QINT       = 16,
  parameter int QFRAC      = WIDTH - QINT,
  parameter int MAX_POINTS = (2 ** QFRAC) - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     stall,
  input  logic                     dir_wr_en,
  input  logic [$clog2(QFRAC)-1:0] dir_wr_addr,
  input  logic [QFRAC-1:0]         dir_wr_data,
  output logic                     valid_out,
  output logic [WIDTH-1:0]         u,
  output logic                     busy,
  output logic                     done,
  output logic                     dir_wr_err
);

  localparam int AW = $clog2(QFRAC);
  localparam logic [QFRAC-1:0] LAST_K = QFRAC'(MAX_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [QFRAC-1:0]  v [QFRAC];
  logic [QFRAC-1:0]  x, k, x_next;
  logic [AW-1:0]     c;
  logic              dir_wr_ok;

  // Position of the lowest zero bit of k; the scan runs high-to-low so the
  // last hit wins. A zero always exists because k never reaches all-ones.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    c = '0;
    for (int i = QFRAC - 1; i >= 0; i--) begin
      if (!k[i]) c = AW'(i);
    end
  end

  assign x_next    = x ^ v[c];
  assign busy      = (state == RUN);
  assign dir_wr_ok = dir_wr_en && (state == IDLE) && (int'(dir_wr_addr) < QFRAC);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (!stall && (k == LAST_K)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the direction table is reset explicitly, since the van der Corput
  // defaults must be usable straight out of reset; this keeps it in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QFRAC; i++) v[i] <= QFRAC'(1) << (QFRAC - 1 - i);
    end else if (dir_wr_ok) begin
      v[dir_wr_addr] <= dir_wr_data;
    end
  end

  // Sticky until reset: a write outside IDLE is dropped but flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             dir_wr_err <= 1'b0;
    else if (dir_wr_en && (state != IDLE))  dir_wr_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      k         <= '0;
      u         <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        x <= '0;
        k <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              x <= '0;
              k <= '0;
            end
          end
          RUN: begin
            if (!stall) begin
              x         <= x_next;
              k         <= k + 1'b1;
              u         <= {{QINT{1'b0}}, x_next};
              valid_out <= 1'b1;
            end
          end
          DONE:    done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Self-checking bench for sobol_seq_gen: a Gray-code model fills a scoreboard
// queue at start, and a negedge monitor pops and compares every valid sample.
module tb_sobol_seq_gen;

  localparam int WIDTH = 32;
  localparam int QINT  = 16;
  localparam int QFRAC = 16;
  localparam int MP    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, abort = 1'b0, stall = 1'b0, dir_wr_en = 1'b0;
  logic [3:0]        dir_wr_addr = '0;
  logic [QFRAC-1:0]  dir_wr_data = '0;
  logic              valid_out, busy, done, dir_wr_err;
  logic [WIDTH-1:0]  u;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic [QFRAC-1:0] tv [QFRAC];

  sobol_seq_gen #(.WIDTH(WIDTH), .QINT(QINT), .MAX_POINTS(MP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .dir_wr_en(dir_wr_en), .dir_wr_addr(dir_wr_addr), .dir_wr_data(dir_wr_data),
    .valid_out(valid_out), .u(u), .busy(busy), .done(done), .dir_wr_err(dir_wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Point n (1-based) is the XOR of the v_j selected by the bits of gray(n).
  function automatic logic [WIDTH-1:0] model_point(input int n);
    int g;
    logic [QFRAC-1:0] acc;
    g = n ^ (n >> 1);
    acc = '0;
    for (int j = 0; j < QFRAC; j++) if (g[j]) acc ^= tv[j];
    return {{QINT{1'b0}}, acc};
  endfunction

  task automatic default_table();
    for (int i = 0; i < QFRAC; i++) begin
      tv[i] = '0;
      tv[i][QFRAC-1-i] = 1'b1;
    end
  endtask

  task automatic push_run();
    for (int n = 1; n <= MP; n++) exp_q.push_back(model_point(n));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && valid_out) begin
      check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("u_stream", u, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 0; abort = 0; stall = 0; dir_wr_en = 0;
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    cyc();
    default_table();
    exp_q.delete();
  endtask

  task automatic do_start();
    push_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_run();
    int seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cyc();
      if (done) seen = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    cyc();
    check("done_width", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic plain_run();
    do_start();
    check("first_busy", 32'(busy), 32'd1);
    check("latency_v0", 32'(valid_out), 32'd0);
    for (int i = 0; i < MP; i++) begin
      cyc();
      check("run_valid", 32'(valid_out), 32'd1);
      if (i < MP - 1) check("run_busy", 32'(busy), 32'd1);
    end
    finish_run();
  endtask

  initial begin
    int nval, dcnt;
    int pat [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    default_table();
    #2;
    check("rst_u", u, 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(dir_wr_err), 32'd0);
    do_reset();

    // Default table, two back-to-back runs
    plain_run();
    plain_run();

    // Stall toggling inside a run
    do_start();
    for (int i = 0; i < 8; i++) begin
      stall = pat[i][0];
      cyc();
      check("stall_valid", 32'(valid_out), 32'(!pat[i][0]));
    end
    stall = 1'b0;
    finish_run();

    // Table writes in IDLE, the second in the same cycle as start
    dir_wr_en = 1'b1; dir_wr_addr = 4'd0; dir_wr_data = 16'h0001; tv[0] = 16'h0001;
    cyc();
    dir_wr_addr = 4'd1; dir_wr_data = 16'h0003; tv[1] = 16'h0003;
    do_start();
    dir_wr_en = 1'b0;
    check("idle_wr_err", 32'(dir_wr_err), 32'd0);
    finish_run();

    // Writes during RUN are dropped and flagged
    do_reset();
    do_start();
    dir_wr_en = 1'b1; dir_wr_addr = 4'd0; dir_wr_data = 16'hFFFF;
    cyc();
    dir_wr_en = 1'b0;
    check("wr_err_set", 32'(dir_wr_err), 32'd1);
    finish_run();
    plain_run();
    check("wr_err_sticky", 32'(dir_wr_err), 32'd1);
    do_reset();
    check("wr_err_clr", 32'(dir_wr_err), 32'd0);

    // Abort on the third valid cycle
    do_start();
    nval = 0;
    for (int i = 0; i < 10 && nval < 3; i++) begin
      cyc();
      if (valid_out) nval++;
    end
    check("abort_at3", 32'(nval), 32'd3);
    abort = 1'b1;
    dcnt = done_cnt;
    cyc();
    abort = 1'b0;
    check("abort_valid", 32'(valid_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_left", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (4) cyc();
    check("abort_nodone", 32'(done_cnt), 32'(dcnt));
    plain_run();

    // Asynchronous reset mid-run
    do_start();
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_u", u, 32'd0);
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    default_table();
    #3 rst_n = 1'b1;
    cyc();
    plain_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
